// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register with a free-running bit counter that
// flags every completed WIDTH-bit word with a one-cycle word_valid pulse.
module sipo_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic                     d,
    output logic [WIDTH-1:0]         q,
    output logic                     word_valid,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     sout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wv_q, wv_d;
    logic             sout_q, sout_d;

    logic [WIDTH-1:0] shifted;
    logic             exit_bit;

    // Shifted window: the new bit enters at one end, everything moves one place.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shifted[gi] = d;
                end else begin : g_mv
                    assign shifted[gi] = q_q[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign shifted[gi] = d;
                end else begin : g_mv
                    assign shifted[gi] = q_q[gi+1];
                end
            end
        end
    endgenerate

    assign exit_bit = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        sout_d = sout_q;
        wv_d   = 1'b0;
        if (shift_en) begin
            q_d    = shifted;
            sout_d = exit_bit;
            // The shift taken at the last count completes a word.
            if (cnt_q == LAST_BIT) begin
                cnt_d = '0;
                wv_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q    <= '0;
            cnt_q  <= '0;
            wv_q   <= 1'b0;
            sout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            wv_q   <= wv_d;
            sout_q <= sout_d;
        end
    end

    assign q          = q_q;
    assign word_valid = wv_q;
    assign bit_cnt    = cnt_q;
    assign sout       = sout_q;

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Scoreboard bench for sipo_shift_reg: one MSB-first and one LSB-first instance,
// directed vectors with hand-computed expectations checked by a separate monitor.
module tb_sipo_shift_reg;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance "m": MSB_FIRST=1, instance "l": MSB_FIRST=0
    logic       rst_n_m = 1'b0, en_m = 1'b0, d_m = 1'b0;
    logic       rst_n_l = 1'b0, en_l = 1'b0, d_l = 1'b0;
    logic [3:0] q_m, q_l;
    logic       wv_m, wv_l, sout_m, sout_l;
    logic [1:0] cnt_m, cnt_l;

    sipo_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n_m), .shift_en(en_m), .d(d_m),
        .q(q_m), .word_valid(wv_m), .bit_cnt(cnt_m), .sout(sout_m)
    );

    sipo_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n_l), .shift_en(en_l), .d(d_l),
        .q(q_l), .word_valid(wv_l), .bit_cnt(cnt_l), .sout(sout_l)
    );

    typedef struct {
        bit         sel_l;
        string      tag;
        logic [3:0] q;
        logic       wv;
        logic [1:0] cnt;
        logic       sout;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Drive one edge worth of stimulus and queue what must appear after that edge.
    task automatic step(input bit sel_l, input string tag, input logic rn, input logic en,
                        input logic din, input logic [3:0] eq, input logic ewv,
                        input logic [1:0] ecnt, input logic esout);
        exp_t e;
        @(negedge clk);
        if (sel_l) begin
            rst_n_l = rn; en_l = en; d_l = din;
        end else begin
            rst_n_m = rn; en_m = en; d_m = din;
        end
        e.sel_l = sel_l; e.tag = tag; e.q = eq; e.wv = ewv; e.cnt = ecnt; e.sout = esout;
        sb.push_back(e);
    endtask

    // Monitor: the DUT presents a result every edge; compare it against the oldest entry.
    initial begin
        exp_t       e;
        logic [3:0] aq;
        logic       awv, asout;
        logic [1:0] acnt;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                aq    = e.sel_l ? q_l    : q_m;
                awv   = e.sel_l ? wv_l   : wv_m;
                acnt  = e.sel_l ? cnt_l  : cnt_m;
                asout = e.sel_l ? sout_l : sout_m;
                n_checks += 4;
                if (aq !== e.q) begin
                    n_fail++;
                    $display("FAIL %s q: got %b expected %b", e.tag, aq, e.q);
                end
                if (awv !== e.wv) begin
                    n_fail++;
                    $display("FAIL %s word_valid: got %b expected %b", e.tag, awv, e.wv);
                end
                if (acnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s bit_cnt: got %0d expected %0d", e.tag, acnt, e.cnt);
                end
                if (asout !== e.sout) begin
                    n_fail++;
                    $display("FAIL %s sout: got %b expected %b", e.tag, asout, e.sout);
                end
                $display("check %s: q=%b wv=%b cnt=%0d sout=%b", e.tag, aq, awv, acnt, asout);
            end
        end
    end

    initial begin
        // 1: reset with d=1, shift_en=1 for two edges
        step(0, "rst0",  0, 1, 1, 4'b0000, 0, 2'd0, 0);
        step(0, "rst1",  0, 1, 1, 4'b0000, 0, 2'd0, 0);
        // 2: MSB-first word 1011
        step(0, "w1b0",  1, 1, 1, 4'b0001, 0, 2'd1, 0);
        step(0, "w1b1",  1, 1, 0, 4'b0010, 0, 2'd2, 0);
        step(0, "w1b2",  1, 1, 1, 4'b0101, 0, 2'd3, 0);
        step(0, "w1b3",  1, 1, 1, 4'b1011, 1, 2'd0, 0);
        // 3: back-to-back word of zeros, old bits fall out of sout
        step(0, "w2b0",  1, 1, 0, 4'b0110, 0, 2'd1, 1);
        step(0, "w2b1",  1, 1, 0, 4'b1100, 0, 2'd2, 0);
        step(0, "w2b2",  1, 1, 0, 4'b1000, 0, 2'd3, 1);
        step(0, "w2b3",  1, 1, 0, 4'b0000, 1, 2'd0, 1);
        // 4: enable gating holds state and suppresses word_valid
        step(0, "en_b0", 1, 1, 1, 4'b0001, 0, 2'd1, 0);
        step(0, "hold0", 1, 0, 0, 4'b0001, 0, 2'd1, 0);
        step(0, "hold1", 1, 0, 1, 4'b0001, 0, 2'd1, 0);
        step(0, "hold2", 1, 0, 1, 4'b0001, 0, 2'd1, 0);
        step(0, "en_b1", 1, 1, 1, 4'b0011, 0, 2'd2, 0);
        // 5: reset mid-word discards the partial word
        step(0, "rst2",  0, 1, 1, 4'b0000, 0, 2'd0, 0);
        step(0, "p_b0",  1, 1, 1, 4'b0001, 0, 2'd1, 0);
        step(0, "p_b1",  1, 1, 1, 4'b0011, 0, 2'd2, 0);
        step(0, "p_b2",  1, 1, 1, 4'b0111, 0, 2'd3, 0);
        step(0, "rst3",  0, 1, 1, 4'b0000, 0, 2'd0, 0);
        step(0, "w3b0",  1, 1, 1, 4'b0001, 0, 2'd1, 0);
        step(0, "w3b1",  1, 1, 0, 4'b0010, 0, 2'd2, 0);
        step(0, "w3b2",  1, 1, 1, 4'b0101, 0, 2'd3, 0);
        step(0, "w3b3",  1, 1, 0, 4'b1010, 1, 2'd0, 0);
        // 6: LSB-first instance (held in reset until now)
        step(1, "l_rst", 0, 1, 1, 4'b0000, 0, 2'd0, 0);
        step(1, "l_b0",  1, 1, 1, 4'b1000, 0, 2'd1, 0);
        step(1, "l_b1",  1, 1, 0, 4'b0100, 0, 2'd2, 0);
        step(1, "l_b2",  1, 1, 1, 4'b1010, 0, 2'd3, 0);
        step(1, "l_b3",  1, 1, 1, 4'b1101, 1, 2'd0, 0);
        step(1, "l_b4",  1, 1, 0, 4'b0110, 0, 2'd1, 1);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
